// File: rtl/uart_rx_fifo_interface.sv
// uart_rx_fifo_interface: DEPTH-word receive FIFO with Count/Full/sticky Overrun status;
// defining RX_FIFO_ERROR_TAG_EN stores a frame-error tag with each word.
module uart_rx_fifo_interface #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int COUNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 Clock,
    input  logic                 ResetN,
`ifdef RX_FIFO_ERROR_TAG_EN
    input  logic                 FrameErrorIn,
    output logic                 FrameErrorOut,
`endif
    input  logic [WORD_SIZE-1:0] DataIn,
    input  logic                 SetFlag,
    input  logic                 ClearFlag,
    input  logic                 ClearOverrun,
    output logic [WORD_SIZE-1:0] DataOut,
    output logic                 Flag,
    output logic                 Full,
    output logic [COUNT_W-1:0]   Count,
    output logic                 Overrun
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef RX_FIFO_ERROR_TAG_EN
    localparam int SW = WORD_SIZE + 1;
`else
    localparam int SW = WORD_SIZE;
`endif
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);
    logic [SW-1:0]      mem_q [DEPTH];
    logic [SW-1:0]      wdata, head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               push, pop, drop;
`ifdef RX_FIFO_ERROR_TAG_EN
    assign wdata = {FrameErrorIn, DataIn};
    assign FrameErrorOut = Flag & head[WORD_SIZE];
`else
    assign wdata = DataIn;
`endif
    // A pop at full frees the slot, so a simultaneous push is accepted.
    always_comb begin
        pop       = ClearFlag && (count_q != '0);
        push      = SetFlag && ((count_q != FULL_CNT) || pop);
        drop      = SetFlag && !push;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + COUNT_W'(push) - COUNT_W'(pop);
        overrun_d = drop || (overrun_q && !ClearOverrun);
    end
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end
    always_ff @(posedge Clock) begin
        if (ResetN && push) mem_q[wr_ptr_q] <= wdata;
    end
    assign head    = mem_q[rd_ptr_q];
    assign Flag    = count_q != '0;
    assign Full    = count_q == FULL_CNT;
    assign Count   = count_q;
    assign Overrun = overrun_q;
    assign DataOut = Flag ? head[WORD_SIZE-1:0] : '0;
endmodule

// File: tb/tb_uart_rx_fifo_interface.sv
// tb_uart_rx_fifo_interface: directed scoreboard bench for the default 8-bit, 4-deep build.
module tb_uart_rx_fifo_interface;
    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       SetFlag = 1'b0;
    logic       ClearFlag = 1'b0;
    logic       ClearOverrun = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic [7:0] DataOut;
    logic       Flag, Full, Overrun;
    logic [2:0] Count;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    logic       ov_m = 1'b0;

    uart_rx_fifo_interface #(.WORD_SIZE(8), .DEPTH(4)) dut (
        .Clock(Clock), .ResetN(ResetN), .DataIn(DataIn), .SetFlag(SetFlag),
        .ClearFlag(ClearFlag), .ClearOverrun(ClearOverrun), .DataOut(DataOut),
        .Flag(Flag), .Full(Full), .Count(Count), .Overrun(Overrun)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict with the queue model, pop-check the head before the edge, then check status.
    task automatic cyc(input logic r, input logic s, input logic c, input logic co, input logic [7:0] d);
        logic pop_m, push_m, drop_m;
        ResetN = r; SetFlag = s; ClearFlag = c; ClearOverrun = co; DataIn = d;
        if (!r) begin
            exp_q.delete();
            ov_m = 1'b0;
        end else begin
            pop_m  = c && exp_q.size() > 0;
            push_m = s && (exp_q.size() < 4 || pop_m);
            drop_m = s && !push_m;
            if (pop_m) begin
                chk("pop_head", DataOut, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (push_m) exp_q.push_back(d);
            ov_m = drop_m || (ov_m && !co);
        end
        @(posedge Clock);
        #1;
        chk("count", {5'b0, Count}, 8'(exp_q.size()));
        chk("flag", {7'b0, Flag}, {7'b0, exp_q.size() != 0});
        chk("full", {7'b0, Full}, {7'b0, exp_q.size() == 4});
        chk("overrun", {7'b0, Overrun}, {7'b0, ov_m});
        chk("dataout", DataOut, exp_q.size() != 0 ? exp_q[0] : 8'h00);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'hAA);
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 8'(i * 8'h11));
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 8'(i * 8'h11));
        cyc(1, 1, 0, 0, 8'h55);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 8'(i * 8'h11));
        cyc(1, 1, 1, 0, 8'h66);
        cyc(1, 1, 0, 1, 8'h99);
        cyc(1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h77);
        cyc(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 8'(8'h80 + i));
            cyc(1, 0, 1, 0, 8'h00);
        end
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 8'(8'hC0 + i));
        cyc(0, 1, 1, 0, 8'hFF);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
